// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Counter must hold WIDTH-1; $clog2 of WIDTH covers that for WIDTH >= 2.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_addsub_w.sv
// Combinational subtractor from the adder family: {c_out,diff} = a + ~b + 1.
// c_out=1 means a >= b (no borrow).
module div_addsub_w #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         c_out
);
    assign {c_out, diff} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake;
// one quotient bit is resolved per clock.
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;

    logic [WIDTH-1:0] rem_sh, quo_sh, rem_nx, quo_nx;
    logic [WIDTH:0]   trial;
    logic             no_borrow;

    assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign quo_sh = {quo_q[WIDTH-2:0], 1'b0};

    div_addsub_w #(.W(WIDTH + 1)) u_sub (
        .a     ({1'b0, rem_sh}),
        .b     ({1'b0, dvs_q}),
        .diff  (trial),
        .c_out (no_borrow)
    );

    // Restore on borrow: keep the shifted remainder, quotient bit stays 0.
    assign rem_nx = no_borrow ? trial[WIDTH-1:0] : rem_sh;
    assign quo_nx = {quo_sh[WIDTH-1:1], no_borrow};

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (divisor == '0) ? DONE : RUN;
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvs_q       <= divisor;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                        end else begin
                            rem_q <= '0;
                            quo_q <= dividend;
                            cnt_q <= CW'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    // Results land on the last step so they are valid with done.
                    if (cnt_q == '0) begin
                        quotient  <= quo_nx;
                        remainder <= rem_nx;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and exhaustive checks for seq_restoring_div at WIDTH=4.
module tb_seq_restoring_div;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int tests = 0;
    int fails = 0;

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one divide; returns edges from start to done (acceptance edge = 1).
    task automatic run_div(input int a, input int b, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = W'(a); divisor = W'(b);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (lat >= 20) chk("done_timeout", lat, 0);
    endtask

    task automatic div_chk(input string tag, input int a, input int b,
                           input int eq, input int er, input int ez, input int elat);
        int lat;
        run_div(a, b, lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"},   int'(quotient),    eq);
        chk({tag, "_r"},   int'(remainder),   er);
        chk({tag, "_dbz"}, int'(div_by_zero), ez);
    endtask

    initial begin
        int lat, ndone;
        rst = 1'b1; start = 1'b1; dividend = 4'd9; divisor = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q",    int'(quotient), 0);
        chk("rst_r",    int'(remainder), 0);
        chk("rst_dbz",  int'(div_by_zero), 0);
        rst = 1'b0; start = 1'b0;

        div_chk("12d5", 12, 5, 2, 2, 0, 5);
        @(negedge clk);
        chk("done_pulse_width", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("held_q", int'(quotient), 2);
        div_chk("15d1", 15, 1, 15, 0, 0, 5);
        div_chk("7d7",  7, 7, 1, 0, 0, 5);
        div_chk("3d7",  3, 7, 0, 3, 0, 5);
        div_chk("5d0",  5, 0, 15, 5, 1, 1);
        div_chk("9d2",  9, 2, 4, 1, 0, 5);

        // Re-pulsed start and operand changes during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk);
        @(negedge clk);
        dividend = 4'd1; divisor = 4'd1;
        chk("run_busy", int'(busy), 1);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin dividend = 4'd15; divisor = 4'd0; end
            if (i == 3) start = 1'b0;
            @(posedge clk); @(negedge clk);
            if (done) begin
                ndone++;
                chk("busy_ignored_q", int'(quotient), 2);
                chk("busy_ignored_r", int'(remainder), 2);
            end
        end
        start = 1'b0;
        chk("busy_one_done", ndone, 1);

        // Reset two cycles into RUN abandons the divide.
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_q", int'(quotient), 0);
        chk("midrst_r", int'(remainder), 0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        div_chk("14d3", 14, 3, 4, 2, 0, 5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a, b, lat);
                if (b == 0) begin
                    chk("sweep_q0", int'(quotient), 15);
                    chk("sweep_r0", int'(remainder), a);
                    chk("sweep_z0", int'(div_by_zero), 1);
                end else begin
                    chk("sweep_q", int'(quotient), a / b);
                    chk("sweep_r", int'(remainder), a % b);
                    chk("sweep_z", int'(div_by_zero), 0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
